qupls4_regread_arbiter: RTL



---
 rtl/qupls4_regread_arbiter_if.sv | 26 ++
 rtl/qupls4_regread_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/qupls4_regread_arbiter_if.sv
// Request/read-port bundle between the reservation stations and the
// register-read arbiter. The arbiter is the slave side.
interface qupls4_regread_arbiter_if #(
    parameter int NREQ  = 16,
    parameter int NPORT = 8,
    parameter int PREGW = 9
);
    logic                   flush;
    logic [NREQ-1:0]        req_v;
    logic [NREQ*PREGW-1:0]  req_pRn;
    logic [NREQ-1:0]        req_grant;
    logic [NPORT*PREGW-1:0] rf_ra;
    logic [NPORT-1:0]       rf_rav;
    logic [NPORT*PREGW-1:0] prn;
    logic [NPORT-1:0]       prnv;

    modport master (
        output flush, req_v, req_pRn,
        input  req_grant, rf_ra, rf_rav, prn, prnv
    );

    modport slave (
        input  flush, req_v, req_pRn,
        output req_grant, rf_ra, rf_rav, prn, prnv
    );
endinterface

// File: rtl/qupls4_regread_arbiter.sv
// Register-file read-port arbiter. Picks up to NPORT distinct registers per
// cycle from the missing-operand request slots, round-robin starting at
// rr_ptr, and delays the issued addresses RF_LAT cycles so they line up with
// the RF read data. Registers still in flight (current rf_ra plus the delay
// pipeline, i.e. the last RF_LAT+1 issues) are not read again.
module qupls4_regread_arbiter #(
    parameter int NREQ   = 16,
    parameter int NPORT  = 8,
    parameter int RF_LAT = 1,
    parameter int PREGW  = 9
) (
    input  logic clk,
    input  logic rst,
    qupls4_regread_arbiter_if.slave bus
);

    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = $clog2(NPORT + 1);

    logic [IDXW-1:0]  rr_ptr;
    logic [PREGW-1:0] rf_ra_q [NPORT];
    logic [NPORT-1:0] rf_rav_q;
    logic [NREQ-1:0]  req_grant_q;

    // Alignment pipeline; its valid entries together with rf_ra form the
    // in-flight table, so one set of registers serves both purposes.
    logic [PREGW-1:0] pipe_ra [RF_LAT][NPORT];
    logic [NPORT-1:0] pipe_v  [RF_LAT];

    logic [PREGW-1:0] slot_reg [NREQ];
    logic [NREQ-1:0]  inflight_hit;
    logic [NREQ-1:0]  eligible;

    logic [PREGW-1:0] ra_n [NPORT];
    logic [NPORT-1:0] rav_n;
    logic [NREQ-1:0]  grant_n;
    logic [IDXW-1:0]  rr_n;
    logic [IDXW-1:0]  slot;
    logic [CNTW-1:0]  used;
    logic             shared;

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign slot_reg[i] = bus.req_pRn[i*PREGW +: PREGW];
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        assign bus.rf_ra[p*PREGW +: PREGW] = rf_ra_q[p];
        assign bus.prn[p*PREGW +: PREGW]   = pipe_ra[RF_LAT-1][p];
    end

    assign bus.rf_rav    = rf_rav_q;
    assign bus.prnv      = pipe_v[RF_LAT-1];
    assign bus.req_grant = req_grant_q;

    // A slot is eligible when it requests a nonzero register not already in flight
    always_comb begin
        inflight_hit = '0;
        eligible     = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (rf_rav_q[p] && rf_ra_q[p] == slot_reg[i])
                    inflight_hit[i] = 1'b1;
                for (int s = 0; s < RF_LAT; s++) begin
                    if (pipe_v[s][p] && pipe_ra[s][p] == slot_reg[i])
                        inflight_hit[i] = 1'b1;
                end
            end
            eligible[i] = bus.req_v[i] && (slot_reg[i] != '0) && !inflight_hit[i];
        end
    end

    // Round-robin scan: new registers take ascending ports, repeats share a port
    always_comb begin
        for (int p = 0; p < NPORT; p++) ra_n[p] = '0;
        rav_n   = '0;
        grant_n = '0;
        rr_n    = rr_ptr;
        used    = '0;
        slot    = '0;
        shared  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            slot = rr_ptr + IDXW'(k);
            if (eligible[slot]) begin
                shared = 1'b0;
                for (int p = 0; p < NPORT; p++) begin
                    if (rav_n[p] && ra_n[p] == slot_reg[slot])
                        shared = 1'b1;
                end
                if (shared) begin
                    grant_n[slot] = 1'b1;
                end else if (used < CNTW'(NPORT)) begin
                    for (int p = 0; p < NPORT; p++) begin
                        if (CNTW'(p) == used) begin
                            ra_n[p]  = slot_reg[slot];
                            rav_n[p] = 1'b1;
                        end
                    end
                    used          = used + 1'b1;
                    grant_n[slot] = 1'b1;
                    rr_n          = slot + 1'b1;
                end
            end
        end
    end

    // Register the allocation, advance the pointer and shift the alignment pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            rf_rav_q    <= '0;
            req_grant_q <= '0;
            for (int p = 0; p < NPORT; p++) rf_ra_q[p] <= '0;
            for (int s = 0; s < RF_LAT; s++) begin
                pipe_v[s] <= '0;
                for (int p = 0; p < NPORT; p++) pipe_ra[s][p] <= '0;
            end
        end else if (bus.flush) begin
            // Pointer is kept so fairness survives a branch miss
            rf_rav_q    <= '0;
            req_grant_q <= '0;
            for (int p = 0; p < NPORT; p++) rf_ra_q[p] <= '0;
            for (int s = 0; s < RF_LAT; s++) pipe_v[s] <= '0;
        end else begin
            rr_ptr      <= rr_n;
            rf_ra_q     <= ra_n;
            rf_rav_q    <= rav_n;
            req_grant_q <= grant_n;
            pipe_ra[0]  <= rf_ra_q;
            pipe_v[0]   <= rf_rav_q;
            for (int s = 1; s < RF_LAT; s++) begin
                pipe_ra[s] <= pipe_ra[s-1];
                pipe_v[s]  <= pipe_v[s-1];
            end
        end
    end

endmodule
